// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life grid blocks: scan-out states,
// default frame marker and the grid edge length used by the cell array.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        GEN,
        DATA
    } state_t;

    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
    localparam int unsigned GRID_SIZE      = 10;

endpackage

// File: rtl/grid_scanout.sv
// Snapshots the live grid on request and streams it as a byte frame:
// header, frame counter, then the packed cells LSB first.
module grid_scanout
    import gol_pkg::*;
#(
    parameter int unsigned GRIDSIZE = GRID_SIZE,
    parameter logic [7:0]  HEADER   = HEADER_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [GRIDSIZE*GRIDSIZE-1:0]   grid_in,
    input  logic                           frame_req,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           tx_last,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned N    = GRIDSIZE * GRIDSIZE;
    localparam int unsigned NB   = (N + 7) / 8;
    localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned LAST = NB - 1;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_snap;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_next;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_next;
    logic            r_overrun;
    logic            w_capture;
    logic            w_last_byte;
    logic [NB*8-1:0] w_pad;
    logic [7:0]      w_byte;

    // Cells past N in the final byte read as zero via the zero-extending cast.
    assign w_pad       = (NB*8)'(r_snap);
    assign w_last_byte = (r_idx == IW'(LAST));

    always_comb begin
        w_byte = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (r_idx == IW'(k)) begin
                w_byte = w_pad[k*8 +: 8];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        tx_last    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_req) begin
                    w_next    = HDR;
                    w_capture = 1'b1;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    w_next = GEN;
                end
            end
            GEN: begin
                tx_valid = 1'b1;
                tx_data  = r_cnt;
                if (tx_ready) begin
                    w_next     = DATA;
                    w_idx_next = '0;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = w_byte;
                tx_last  = w_last_byte;
                if (tx_ready) begin
                    if (w_last_byte) begin
                        w_next     = IDLE;
                        w_cnt_next = r_cnt + 8'd1;
                    end else begin
                        w_idx_next = r_idx + IW'(1);
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_snap    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_snap <= grid_in;
            end
            // Any request outside IDLE, including the final-transfer cycle, is an overrun.
            if (frame_req && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign overrun = r_overrun;

endmodule
